// File: rtl/ena_strobe_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ena_strobe_checker_pkg
// Description : Shared FSM encoding and default divider ratios.
// Revision    : 1.0 - initial release
// ============================================================================
package ena_strobe_checker_pkg;

    localparam int DIV_RATIO_DEF  = 10;
    localparam int TEST_RATIO_DEF = 2;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ACQUIRE = 2'd1;
    localparam logic [1:0] c_ST_LOCKED  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ena_strobe_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : ena_strobe_checker_if
// Description : Strobe input and measurement/status outputs of the checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface ena_strobe_checker_if #(
    parameter int CNT_W = 16
);
    logic             testn;
    logic             ena;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output testn, ena,
        input  period, period_valid, locked, err, err_count
    );

    modport slave (
        input  testn, ena,
        output period, period_valid, locked, err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/ena_strobe_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Loadable up-counter that holds at all-ones; async active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;
endmodule
`default_nettype wire

// File: rtl/ena_strobe_checker.sv
`default_nettype none
// ============================================================================
// Module      : ena_strobe_checker
// Description : Measures ena strobe spacing, tracks lock to the expected ratio.
// Revision    : 1.0 - initial release
// ============================================================================
module ena_strobe_checker
    import ena_strobe_checker_pkg::*;
#(
    parameter int DIV_RATIO  = DIV_RATIO_DEF,
    parameter int TEST_RATIO = TEST_RATIO_DEF,
    parameter int CNT_W      = 16,
    parameter int LOCK_COUNT = 4
) (
    input  logic                  div_clk,
    input  logic                  reset,
    ena_strobe_checker_if.slave   bus
);
    localparam int c_MW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] c_EXP_DIV   = CNT_W'(DIV_RATIO);
    localparam logic [CNT_W-1:0] c_EXP_TEST  = CNT_W'(TEST_RATIO);
    localparam logic [CNT_W-1:0] c_TO_DIV    = CNT_W'(2 * DIV_RATIO - 1);
    localparam logic [CNT_W-1:0] c_TO_TEST   = CNT_W'(2 * TEST_RATIO - 1);
    localparam logic [c_MW-1:0]  c_LOCK_LAST = c_MW'(LOCK_COUNT - 1);
    localparam logic [c_MW-1:0]  c_LOCK_FULL = c_MW'(LOCK_COUNT);

    logic [1:0]       r_state;
    logic             r_testn_q;
    logic [c_MW-1:0]  r_match;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt;
    logic [7:0]       w_err_count;
    logic [CNT_W-1:0] w_exp;
    logic [CNT_W-1:0] w_to_lim;
    logic             w_mode_chg;
    logic             w_match;
    logic             w_timeout;
    logic [1:0]       w_state_nxt;
    logic [c_MW-1:0]  w_match_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             w_pv_nxt;
    logic             w_locked_nxt;
    logic             w_err_nxt;

    sat_counter #(.WIDTH(CNT_W)) u_interval_cnt (
        .clk        (div_clk),
        .rst_n      (reset),
        .i_load     (bus.ena),
        .i_load_val (CNT_W'(1)),
        .i_inc      (1'b1),
        .o_count    (w_cnt)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk        (div_clk),
        .rst_n      (reset),
        .i_load     (1'b0),
        .i_load_val (8'd0),
        .i_inc      (w_err_nxt),
        .o_count    (w_err_count)
    );

    assign w_exp      = bus.testn ? c_EXP_DIV : c_EXP_TEST;
    assign w_to_lim   = bus.testn ? c_TO_DIV  : c_TO_TEST;
    assign w_mode_chg = (bus.testn != r_testn_q);
    assign w_match    = (w_cnt == w_exp);
    // Timeout fires on the edge that would carry the counter to twice the ratio.
    assign w_timeout  = !bus.ena && (w_cnt >= w_to_lim);

    always_comb begin
        w_state_nxt  = r_state;
        w_match_nxt  = r_match;
        w_period_nxt = r_period;
        w_pv_nxt     = 1'b0;
        w_locked_nxt = r_locked;
        w_err_nxt    = 1'b0;

        if (w_mode_chg) begin
            w_locked_nxt = 1'b0;
            w_match_nxt  = '0;
            w_state_nxt  = bus.ena ? c_ST_ACQUIRE : c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.ena) begin
                        w_state_nxt = c_ST_ACQUIRE;
                        w_match_nxt = '0;
                    end
                end
                c_ST_ACQUIRE: begin
                    if (bus.ena) begin
                        w_pv_nxt     = 1'b1;
                        w_period_nxt = w_cnt;
                        if (w_match) begin
                            if (r_match == c_LOCK_LAST) begin
                                w_match_nxt  = c_LOCK_FULL;
                                w_state_nxt  = c_ST_LOCKED;
                                w_locked_nxt = 1'b1;
                            end else begin
                                w_match_nxt = r_match + c_MW'(1);
                            end
                        end else begin
                            w_match_nxt = '0;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    if (bus.ena) begin
                        w_pv_nxt     = 1'b1;
                        w_period_nxt = w_cnt;
                        if (!w_match) begin
                            w_err_nxt    = 1'b1;
                            w_locked_nxt = 1'b0;
                            w_match_nxt  = '0;
                            w_state_nxt  = c_ST_ACQUIRE;
                        end
                    end else if (w_timeout) begin
                        w_err_nxt    = 1'b1;
                        w_locked_nxt = 1'b0;
                        w_match_nxt  = '0;
                        w_state_nxt  = c_ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = c_ST_IDLE;
                    w_locked_nxt = 1'b0;
                    w_match_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge div_clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_testn_q      <= 1'b1;
            r_match        <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_testn_q      <= bus.testn;
            r_match        <= w_match_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_pv_nxt;
            r_locked       <= w_locked_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.locked       = r_locked;
    assign bus.err          = r_err;
    assign bus.err_count    = w_err_count;
endmodule
`default_nettype wire

// File: tb/tb_ena_strobe_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ena_strobe_checker
// Description : Vector table plus cycle scoreboard for ena_strobe_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ena_strobe_checker;
    import ena_strobe_checker_pkg::*;

    localparam int LOCK_N = 4;
    localparam int CMAX   = 65535;

    typedef struct {
        logic        pv;
        logic [15:0] period;
        logic        locked;
        logic        err;
        logic [7:0]  ec;
    } out_t;

    typedef struct {
        int   gap;
        logic testn;
        logic pv;
        int   period;
        logic locked;
        logic err;
        int   ec;
    } vec_t;

    logic div_clk = 1'b0;
    logic reset   = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;
    out_t sb[$];
    vec_t tbl[$];

    // reference model state
    int   m_state, m_cnt, m_match, m_period, m_ec;
    logic m_pv, m_locked, m_err, m_tq;

    ena_strobe_checker_if #(.CNT_W(16)) bus ();

    ena_strobe_checker #(
        .DIV_RATIO  (DIV_RATIO_DEF),
        .TEST_RATIO (TEST_RATIO_DEF),
        .CNT_W      (16),
        .LOCK_COUNT (LOCK_N)
    ) dut (
        .div_clk (div_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial forever #5 div_clk = ~div_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_match = 0; m_period = 0; m_ec = 0;
        m_pv = 0; m_locked = 0; m_err = 0; m_tq = 1'b1;
    endtask

    task automatic model(input logic e, input logic t, output out_t x);
        int ratio;
        if (!reset) begin
            model_reset();
        end else begin
            ratio = t ? DIV_RATIO_DEF : TEST_RATIO_DEF;
            m_pv  = 0;
            m_err = 0;
            if (t != m_tq) begin
                m_locked = 0; m_match = 0;
                m_state  = e ? 1 : 0;
            end else if (m_state == 0) begin
                if (e) begin m_state = 1; m_match = 0; end
            end else if (m_state == 1) begin
                if (e) begin
                    m_pv = 1; m_period = m_cnt;
                    if (m_cnt == ratio) begin
                        m_match++;
                        if (m_match == LOCK_N) begin m_state = 2; m_locked = 1; end
                    end else m_match = 0;
                end
            end else begin
                if (e) begin
                    m_pv = 1; m_period = m_cnt;
                    if (m_cnt != ratio) begin
                        m_err = 1; m_locked = 0; m_match = 0; m_state = 1;
                    end
                end else if (m_cnt + 1 >= 2 * ratio) begin
                    m_err = 1; m_locked = 0; m_match = 0; m_state = 0;
                end
            end
            if (m_err && m_ec < 255) m_ec++;
            m_cnt = e ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
            m_tq  = t;
        end
        x.pv = m_pv; x.period = 16'(m_period); x.locked = m_locked;
        x.err = m_err; x.ec = 8'(m_ec);
    endtask

    task automatic step(input logic e, input logic t);
        out_t x;
        bus.ena   = e;
        bus.testn = t;
        model(e, t, x);
        sb.push_back(x);
        @(posedge div_clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            x = sb.pop_front();
            chk("sb_period_valid", 32'(bus.period_valid), 32'(x.pv));
            chk("sb_period",       32'(bus.period),       32'(x.period));
            chk("sb_locked",       32'(bus.locked),       32'(x.locked));
            chk("sb_err",          32'(bus.err),          32'(x.err));
            chk("sb_err_count",    32'(bus.err_count),    32'(x.ec));
        end
    endtask

    task automatic strobe(input int gap, input logic t);
        for (int k = 0; k < gap - 1; k++) step(1'b0, t);
        step(1'b1, t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin
        int found;
        bus.ena   = 1'b0;
        bus.testn = 1'b1;
        model_reset();

        // gap, testn, pv, period, locked, err, err_count
        tbl.push_back('{3,  1'b1, 1'b0, 0,  1'b0, 1'b0, 0});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 0});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 0});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 0});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b1, 1'b0, 0});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b1, 1'b0, 0});
        tbl.push_back('{7,  1'b1, 1'b1, 7,  1'b0, 1'b1, 1});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1});
        tbl.push_back('{11, 1'b1, 1'b1, 11, 1'b0, 1'b1, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b1, 1'b0, 2});
        tbl.push_back('{1,  1'b0, 1'b0, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{2,  1'b0, 1'b1, 2,  1'b0, 1'b0, 2});
        tbl.push_back('{2,  1'b0, 1'b1, 2,  1'b0, 1'b0, 2});
        tbl.push_back('{2,  1'b0, 1'b1, 2,  1'b0, 1'b0, 2});
        tbl.push_back('{2,  1'b0, 1'b1, 2,  1'b1, 1'b0, 2});
        tbl.push_back('{3,  1'b1, 1'b0, 2,  1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b0, 1'b0, 2});
        tbl.push_back('{10, 1'b1, 1'b1, 10, 1'b1, 1'b0, 2});

        // held in reset with ena toggling: everything stays cleared
        for (int i = 0; i < 5; i++) begin
            step(1'(i % 2), 1'b1);
            chk("rst_period_valid", 32'(bus.period_valid), 32'd0);
            chk("rst_locked",       32'(bus.locked),       32'd0);
            chk("rst_err_count",    32'(bus.err_count),    32'd0);
        end
        reset = 1'b1;

        foreach (tbl[i]) begin
            strobe(tbl[i].gap, tbl[i].testn);
            chk($sformatf("vec%0d_pv", i),     32'(bus.period_valid), 32'(tbl[i].pv));
            chk($sformatf("vec%0d_period", i), 32'(bus.period),       32'(tbl[i].period));
            chk($sformatf("vec%0d_locked", i), 32'(bus.locked),       32'(tbl[i].locked));
            chk($sformatf("vec%0d_err", i),    32'(bus.err),          32'(tbl[i].err));
            chk($sformatf("vec%0d_ec", i),     32'(bus.err_count),    32'(tbl[i].ec));
        end

        // strobes stop while locked: timeout when the counter reaches 20
        found = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1'b0, 1'b1);
            if (bus.err === 1'b1) begin found = k; break; end
        end
        chk("timeout_cycle",  32'(found),          32'd19);
        chk("timeout_locked", 32'(bus.locked),     32'd0);
        chk("timeout_ec",     32'(bus.err_count),  32'd3);
        step(1'b0, 1'b1);
        chk("timeout_err_one_cycle", 32'(bus.err), 32'd0);
        strobe(5, 1'b1);
        chk("idle_first_strobe_pv", 32'(bus.period_valid), 32'd0);

        // repeated lock/mismatch until the error counter saturates
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 4; j++) strobe(10, 1'b1);
            strobe((i % 2) ? 11 : 9, 1'b1);
        end
        chk("sat_ec",      32'(bus.err_count), 32'd255);
        chk("sat_err_hit", 32'(bus.err),       32'd1);

        // asynchronous reset mid-cycle, sampled before any clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("async_ec",     32'(bus.err_count), 32'd0);
        chk("async_locked", 32'(bus.locked),    32'd0);
        chk("async_period", 32'(bus.period),    32'd0);
        model_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        reset = 1'b1;
        strobe(4, 1'b1);
        chk("post_rst_first_pv", 32'(bus.period_valid), 32'd0);
        strobe(10, 1'b1);
        chk("post_rst_pv",     32'(bus.period_valid), 32'd1);
        chk("post_rst_period", 32'(bus.period),       32'd10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ena_strobe_checker.md
Name: ena_strobe_checker

Overview:
Receive-side companion to the clock divider. It samples the divider's enable strobe `ena` in the same `div_clk` domain and measures the interval between strobes. It checks that interval against the expected ratio for the current mode: normal when `testn=1`, test when `testn=0`. It reports lock, per-strobe period and error events, and sits beside the divider as a self-check and bring-up monitor.

Parameters:
DIV_RATIO, 10, expected strobe period in div_clk cycles when testn=1
TEST_RATIO, 2, expected strobe period in div_clk cycles when testn=0
CNT_W, 16, width of the interval counter and the period output
LOCK_COUNT, 4, consecutive matching periods required to declare lock

Ports:
div_clk  input  1  single clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
testn  input  1  mode select, same meaning as at the divider; 0 = test ratio
ena  input  1  enable strobe from the divider, synchronous to div_clk
period  output  CNT_W  last measured strobe-to-strobe interval, in cycles
period_valid  output  1  one-cycle pulse when period updates
locked  output  1  high while LOCK_COUNT+ consecutive periods matched expected
err  output  1  one-cycle pulse on period mismatch or strobe loss while locked
err_count  output  8  saturating count of err pulses since reset

Behaviour:
- Reset (reset=0, async): state=IDLE, interval counter cnt=0, match_cnt=0, period=0, period_valid=0, locked=0, err=0, err_count=0.
- Expected ratio: exp = testn ? DIV_RATIO : TEST_RATIO. testn is registered once (testn_q). A mode change is testn != testn_q.
- Interval counter cnt:
  - Loads 1 at each edge where ena=1.
  - Otherwise increments; saturates at 2^CNT_W-1.
  - Measured period = cnt value at the edge where ena=1. Back-to-back ena gives period 1.
- All outputs are registered. period/period_valid update at the same edge that samples ena=1, i.e. visible the cycle after ena is presented.
- FSM states IDLE, ACQUIRE, LOCKED:
  - IDLE: wait for the first ena. On ena → ACQUIRE, cnt=1, no period_valid (no prior reference).
  - ACQUIRE: on ena, period=cnt and period_valid=1.
    - If cnt==exp: match_cnt++. When match_cnt reaches LOCK_COUNT → LOCKED, locked=1 at that edge.
    - Else match_cnt=0. No err in ACQUIRE.
  - LOCKED: on ena, period=cnt and period_valid=1.
    - If cnt!=exp: err=1, err_count++, locked=0, match_cnt=0 → ACQUIRE.
    - Timeout: no ena while cnt reaches 2*exp → err=1, err_count++, locked=0 → IDLE.
- err_count saturates at 255; never wraps.
- Mode change:
  - Takes priority over every other transition.
  - locked=0, match_cnt=0, no err.
  - If ena is also 1 that cycle → ACQUIRE with cnt=1 and no period_valid. Otherwise → IDLE.
- Lock is reached on the LOCK_COUNT-th matching period after the first strobe, i.e. at strobe number LOCK_COUNT+1.
- Counter saturation in ACQUIRE: period reports the saturated value, treated as a mismatch.
- Mid-operation reset: everything returns to reset values asynchronously. First strobe after release behaves as in IDLE.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/ACQUIRE/LOCKED).
  - Default ratio constants DIV_RATIO_DEF=10 and TEST_RATIO_DEF=2, also used by the divider and its bench.
- One natural sub-module, `sat_counter`: parameterised width, sync load/increment, saturating, async active-low clear.
  - Instantiated for cnt (CNT_W, load-1) and for err_count (8, clear only on reset).

Test Plan:
1. reset=0 for 5 cycles, ena strobing → all outputs 0 throughout; first ena after reset=1 produces no period_valid.
2. testn=1, ena every 10 cycles → period=10 on each valid; locked rises at the 5th strobe and stays high; err never pulses.
3. Locked at ratio 10, one strobe arrives after 7 cycles → period=7, err pulse, err_count=1, locked=0; relock after 4 further matching periods.
4. Locked at ratio 10, strobes stop → err pulse when cnt reaches 20, err_count increments, state IDLE, locked=0.
5. testn 1→0 while locked, ena every 2 cycles → locked drops with no err; period=2 reported; locked after 4 matches at ratio 2; mode change coincident with ena gives no period_valid that cycle.
6. Force 300 mismatches via alternating 9/11 periods, relocking between → err_count stops at 255; reset=0 mid-stream clears it to 0 immediately, without waiting for a clock edge.
